// File: rtl/avmm_csr_pkg.sv
// Shared state/region types and the address-region decode for the Avalon-MM CSR bank.
package avmm_csr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_ERR = 2'd2,
    REG_BAD = 2'd3
  } region_e;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  // RW block first, RO block after it, then the single error-counter word.
  function automatic region_e addr_region(input int addr, input int n_rw, input int n_ro);
    region_e r;
    if (addr < n_rw)               r = REG_RW;
    else if (addr < n_rw + n_ro)   r = REG_RO;
    else if (addr == n_rw + n_ro)  r = REG_ERR;
    else                           r = REG_BAD;
    return r;
  endfunction

endpackage

// File: rtl/avmm_burst_addr_gen.sv
// Burst address counter plus remaining-beat down-counter. The load values bypass
// straight to the outputs so the first beat is handled in the accepting cycle.
module avmm_burst_addr_gen #(
  parameter int AW  = 10,
  parameter int BCW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [AW-1:0]  load_addr_i,
  input  logic [BCW-1:0] load_beats_i,
  input  logic           step_i,
  output logic [AW-1:0]  cur_addr_o,
  output logic           last_beat_o,
  output logic           empty_o
);

  logic [AW-1:0]  addr_q;
  logic [BCW-1:0] rem_q;
  logic [BCW-1:0] cur_rem;

  assign cur_addr_o  = load_i ? load_addr_i  : addr_q;
  assign cur_rem     = load_i ? load_beats_i : rem_q;
  assign last_beat_o = (cur_rem == BCW'(1));
  assign empty_o     = (cur_rem == '0);

  // Address wraps naturally at 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (step_i && !empty_o) begin
      addr_q <= cur_addr_o + AW'(1);
      rem_q  <= cur_rem - BCW'(1);
    end
  end

endmodule

// File: rtl/avmm_csr_bank.sv
// Avalon-MM slave CSR bank: RW control regs, RO status regs, error counter, bursts.
// Optional per-byte write enables under macro AVMM_CSR_BYTEEN_EN.
//
// state    | meaning
// IDLE     | accept next command; its first beat is handled in the accepting cycle
// WR_BURST | take the remaining write beats whenever avs_write is high
// RD_BURST | stall commands while read beats stream out, one per cycle
module avmm_csr_bank
  import avmm_csr_pkg::*;
#(
  parameter  int AW        = 10,
  parameter  int DW        = 32,
  parameter  int MAX_BURST = 1,
  parameter  int N_RW      = 8,
  parameter  int N_RO      = 7,
  localparam int BCW       = $clog2(MAX_BURST) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DW-1:0]       avs_writedata,
  input  logic [DW/8-1:0]     avs_byteenable,
  input  logic [BCW-1:0]      avs_burstcount,
  output logic [DW-1:0]       avs_readdata,
  output logic                avs_readdatavalid,
  output logic                avs_waitrequest,
  output logic [N_RW*DW-1:0]  ctrl_o,
  output logic [N_RW-1:0]     wr_strobe_o,
  input  logic [N_RO*DW-1:0]  status_i
);

  state_e         state_q;
  logic           waitreq_q;
  logic           rdv_q;
  logic [DW-1:0]  rdata_q;
  logic [DW-1:0]  ctrl_q [N_RW];
  logic [N_RW-1:0] wr_strobe_q, wr_strobe_d;
  logic [DW-1:0]  err_q, err_d;

  logic           accept;
  logic           wr_beat, rd_beat;
  logic           step;
  logic [BCW-1:0] beats;
  logic           clamp_raw;
  logic [AW-1:0]  cur_addr;
  logic           last_beat, empty;
  region_e        cur_region;
  logic [DW-1:0]  rd_mux;
  logic [DW-1:0]  wmask;
  logic           be_any;

  // Zero-length bursts mean one beat; oversize bursts are clamped and counted.
  always_comb begin
    beats     = avs_burstcount;
    clamp_raw = 1'b0;
    if (avs_burstcount == '0) begin
      beats = BCW'(1);
    end else if (32'(avs_burstcount) > MAX_BURST) begin
      beats     = BCW'(MAX_BURST);
      clamp_raw = 1'b1;
    end
  end

  assign accept  = (state_q == IDLE) && !waitreq_q && (avs_read || avs_write);
  assign wr_beat = (accept && avs_write) || ((state_q == WR_BURST) && avs_write);
  assign rd_beat = (accept && !avs_write) || ((state_q == RD_BURST) && !empty);
  assign step    = wr_beat || rd_beat;

  avmm_burst_addr_gen #(
    .AW  (AW),
    .BCW (BCW)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (accept),
    .load_addr_i  (avs_address),
    .load_beats_i (beats),
    .step_i       (step),
    .cur_addr_o   (cur_addr),
    .last_beat_o  (last_beat),
    .empty_o      (empty)
  );

  assign cur_region = addr_region(32'(cur_addr), N_RW, N_RO);

`ifdef AVMM_CSR_BYTEEN_EN
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW/8; b++) wmask[b*8 +: 8] = {8{avs_byteenable[b]}};
  end
  assign be_any = |avs_byteenable;
`else
  logic unused_be;
  assign unused_be = ^avs_byteenable;
  assign wmask     = '1;
  assign be_any    = 1'b1;
`endif

  always_comb begin
    rd_mux = DW'(BAD_ADDR_DATA);
    case (cur_region)
      REG_RW: begin
        for (int k = 0; k < N_RW; k++)
          if (cur_addr == AW'(k)) rd_mux = ctrl_q[k];
      end
      REG_RO: begin
        for (int k = 0; k < N_RO; k++)
          if (cur_addr == AW'(N_RW + k)) rd_mux = status_i[k*DW +: DW];
      end
      REG_ERR: rd_mux = err_q;
      default: ;
    endcase
  end

  always_comb begin
    wr_strobe_d = '0;
    if (wr_beat && be_any && (cur_region == REG_RW)) begin
      for (int k = 0; k < N_RW; k++)
        if (cur_addr == AW'(k)) wr_strobe_d[k] = 1'b1;
    end
  end

  // Several error sources can fire together; all are counted, then saturated.
  logic [1:0]    err_inc;
  logic [DW-1:0] err_base;
  logic [DW+1:0] err_sum;

  always_comb begin
    err_inc  = {1'b0, accept && clamp_raw}
             + {1'b0, accept && avs_read && avs_write}
             + {1'b0, step && (cur_region == REG_BAD)};
    err_base = (wr_beat && (cur_region == REG_ERR)) ? '0 : err_q;
    err_sum  = {2'b00, err_base} + {{DW{1'b0}}, err_inc};
    err_d    = (|err_sum[DW+1:DW]) ? '1 : err_sum[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_RW; k++) ctrl_q[k] <= '0;
      wr_strobe_q <= '0;
      err_q       <= '0;
    end else begin
      wr_strobe_q <= wr_strobe_d;
      err_q       <= err_d;
      for (int k = 0; k < N_RW; k++)
        if (wr_strobe_d[k]) ctrl_q[k] <= (ctrl_q[k] & ~wmask) | (avs_writedata & wmask);
    end
  end

  // readdata/readdatavalid trail the issuing cycle by one, so RD_BURST spans exactly the valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      waitreq_q <= 1'b1;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rdv_q <= rd_beat;
      if (rd_beat) rdata_q <= rd_mux;
      case (state_q)
        IDLE: begin
          if (accept && !avs_write) begin
            state_q   <= RD_BURST;
            waitreq_q <= 1'b1;
          end else begin
            if (accept && !last_beat) state_q <= WR_BURST;
            waitreq_q <= 1'b0;
          end
        end
        WR_BURST: begin
          if (avs_write && last_beat) state_q <= IDLE;
          waitreq_q <= 1'b0;
        end
        RD_BURST: begin
          if (empty) begin
            state_q   <= IDLE;
            waitreq_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          waitreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_waitrequest   = waitreq_q;
  assign wr_strobe_o       = wr_strobe_q;

  for (genvar k = 0; k < N_RW; k++) begin : g_ctrl
    assign ctrl_o[k*DW +: DW] = ctrl_q[k];
  end

endmodule
